// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory-access stage and its MEM/WB register.
package mem_wb_stage_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] readData;
        logic [31:0] ins;
        logic [4:0]  writeReg;
        logic        memtoReg;
        logic        regWrite;
    } wbBundle_t;

    localparam wbBundle_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the data memory (slave).
interface mem_wb_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );

endinterface

// File: rtl/mem_wb_stage_memwb_reg.sv
// MEM/WB pipeline register: captures the write-back bundle, or a bubble, or a
// faulting instruction retired as a non-writing op with the memerr flag set.
module memwb_reg
    import mem_wb_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  wbBundle_t d,
    input  logic      bubble,
    input  logic      memerr,
    output wbBundle_t q,
    output logic      memerrQ
);

    wbBundle_t errBundle;

    // A faulting op keeps its address and instruction for debug but writes nothing.
    always_comb begin
        errBundle           = WB_BUBBLE;
        errBundle.aluResult = d.aluResult;
        errBundle.ins       = d.ins;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= WB_BUBBLE;
            memerrQ <= 1'b0;
        end else if (bubble) begin
            q       <= WB_BUBBLE;
            memerrQ <= 1'b0;
        end else if (memerr) begin
            q       <= errBundle;
            memerrQ <= 1'b1;
        end else begin
            q       <= d;
            memerrQ <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: drives a variable-latency data memory, stalls upstream
// while an access is outstanding, and retires misaligned or timed-out accesses as faults.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           ALUresultMEM,
    input  logic [31:0]           dmemdata,
    input  logic [31:0]           insMEM,
    input  logic [4:0]            writeregMEM,
    input  logic                  MemtoRegMEM,
    input  logic                  RegWriteMEM,
    input  logic                  MemReadMEM,
    input  logic                  MemWriteMEM,
    mem_wb_stage_if.master        dmem,
    output logic                  stall_mem,
    output logic [31:0]           ALUresultWB,
    output logic [31:0]           readdataWB,
    output logic [31:0]           insWB,
    output logic [4:0]            writeregWB,
    output logic                  MemtoRegWB,
    output logic                  RegWriteWB,
    output logic                  memerrWB
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [0:0]       state, nextState;
    logic [CNT_W-1:0] waitCnt, nextCnt;
    logic             memop, misal, isLoad;
    logic             reqLocal, stallLocal, bubble, memerr, loadDone;
    wbBundle_t        wbIn, wbOut;

    // A store wins when both read and write are set, so only pure reads return data.
    assign memop  = MemReadMEM | MemWriteMEM;
    assign misal  = memop & (ALUresultMEM[1:0] != 2'b00);
    assign isLoad = MemReadMEM & ~MemWriteMEM;

    // Request and stall are gated by reset so an abandoned access drops at once.
    always_comb begin
        reqLocal   = 1'b0;
        stallLocal = 1'b0;
        bubble     = 1'b0;
        memerr     = 1'b0;
        loadDone   = 1'b0;
        nextState  = state;
        nextCnt    = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (misal) begin
                        memerr = 1'b1;
                    end else if (memop) begin
                        reqLocal = 1'b1;
                        if (dmem.dmem_ready) begin
                            loadDone = isLoad;
                        end else begin
                            stallLocal = 1'b1;
                            bubble     = 1'b1;
                            nextState  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    reqLocal = 1'b1;
                    if (dmem.dmem_ready) begin
                        loadDone  = isLoad;
                        nextState = IDLE;
                    end else if (waitCnt == LAST_WAIT) begin
                        memerr    = 1'b1;
                        nextState = IDLE;
                    end else begin
                        stallLocal = 1'b1;
                        bubble     = 1'b1;
                        nextCnt    = waitCnt + CNT_W'(1);
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
        end
    end

    assign dmem.dmem_req   = reqLocal;
    assign dmem.dmem_we    = MemWriteMEM;
    assign dmem.dmem_addr  = ALUresultMEM;
    assign dmem.dmem_wdata = dmemdata;
    assign stall_mem       = stallLocal;

    always_comb begin
        wbIn.aluResult = ALUresultMEM;
        wbIn.readData  = loadDone ? dmem.dmem_rdata : 32'h0;
        wbIn.ins       = insMEM;
        wbIn.writeReg  = writeregMEM;
        wbIn.memtoReg  = MemtoRegMEM;
        wbIn.regWrite  = RegWriteMEM;
    end

    memwb_reg uMemwbReg (
        .clk     (clk),
        .reset   (reset),
        .d       (wbIn),
        .bubble  (bubble),
        .memerr  (memerr),
        .q       (wbOut),
        .memerrQ (memerrWB)
    );

    assign ALUresultWB = wbOut.aluResult;
    assign readdataWB  = wbOut.readData;
    assign insWB       = wbOut.ins;
    assign writeregWB  = wbOut.writeReg;
    assign MemtoRegWB  = wbOut.memtoReg;
    assign RegWriteWB  = wbOut.regWrite;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, multi-cycle corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUresultMEM, dmemdata, insMEM;
    logic [4:0]  writeregMEM;
    logic        MemtoRegMEM, RegWriteMEM, MemReadMEM, MemWriteMEM;
    logic        stall_mem;
    logic [31:0] ALUresultWB, readdataWB, insWB;
    logic [4:0]  writeregWB;
    logic        MemtoRegWB, RegWriteWB, memerrWB;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ALUresultMEM (ALUresultMEM),
        .dmemdata     (dmemdata),
        .insMEM       (insMEM),
        .writeregMEM  (writeregMEM),
        .MemtoRegMEM  (MemtoRegMEM),
        .RegWriteMEM  (RegWriteMEM),
        .MemReadMEM   (MemReadMEM),
        .MemWriteMEM  (MemWriteMEM),
        .dmem         (bus.master),
        .stall_mem    (stall_mem),
        .ALUresultWB  (ALUresultWB),
        .readdataWB   (readdataWB),
        .insWB        (insWB),
        .writeregWB   (writeregWB),
        .MemtoRegWB   (MemtoRegWB),
        .RegWriteWB   (RegWriteWB),
        .memerrWB     (memerrWB)
    );

    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic        memRead, memWrite;
        logic [31:0] aluResult, storeData, ins, rdata;
        logic [4:0]  dst;
        logic        memtoReg, regWrite, ready;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        eReq, eWe, eStall;
        logic [31:0] eAlu, eRd;
        logic [4:0]  eWr;
        logic        eRw, eErr;
    } vec_t;

    stim_t cur;
    vec_t  vecs[8];

    // Reference model: counts how many cycles the current access has already requested.
    int          mReqCycles = 0;
    logic        eReq, eStall;
    logic [31:0] eAlu, eRd, eIns;
    logic [4:0]  eWr;
    logic        eMtr, eRw, eErr;

    function automatic stim_t mkStim(logic rd, logic wr, logic [31:0] alu, logic [31:0] wdata,
                                     logic [31:0] ins, logic [4:0] dst, logic mtr, logic rw,
                                     logic ready, logic [31:0] rdata);
        stim_t s;
        s.memRead = rd;   s.memWrite = wr;  s.aluResult = alu; s.storeData = wdata;
        s.ins = ins;      s.dst = dst;      s.memtoReg = mtr;  s.regWrite = rw;
        s.ready = ready;  s.rdata = rdata;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        cur             = s;
        MemReadMEM      = s.memRead;
        MemWriteMEM     = s.memWrite;
        ALUresultMEM    = s.aluResult;
        dmemdata        = s.storeData;
        insMEM          = s.ins;
        writeregMEM     = s.dst;
        MemtoRegMEM     = s.memtoReg;
        RegWriteMEM     = s.regWrite;
        bus.dmem_ready  = s.ready;
        bus.dmem_rdata  = s.rdata;
    endtask

    task automatic setErr();
        eAlu = cur.aluResult; eRd = 0; eIns = cur.ins; eWr = 0; eMtr = 0; eRw = 0; eErr = 1;
    endtask

    task automatic combPhase();
        logic memop, misal, isLoad, timeoutNow;
        #2;
        memop      = cur.memRead | cur.memWrite;
        misal      = memop && (cur.aluResult[1:0] != 2'b00);
        isLoad     = cur.memRead && !cur.memWrite;
        timeoutNow = 1'b0;
        if (!reset) begin
            eReq = 0; eStall = 0;
        end else begin
            eReq       = (mReqCycles > 0) || (memop && !misal);
            timeoutNow = eReq && !cur.ready && (mReqCycles == TO);
            eStall     = eReq && !cur.ready && !timeoutNow;
        end
        checkOutput("dmem_req", 32'(bus.dmem_req), 32'(eReq));
        checkOutput("stall_mem", 32'(stall_mem), 32'(eStall));
        if (eReq) begin
            checkOutput("dmem_we", 32'(bus.dmem_we), 32'(cur.memWrite));
            checkOutput("dmem_addr", bus.dmem_addr, cur.aluResult);
            checkOutput("dmem_wdata", bus.dmem_wdata, cur.storeData);
        end
        if (!reset || eStall) begin
            eAlu = 0; eRd = 0; eIns = 0; eWr = 0; eMtr = 0; eRw = 0; eErr = 0;
        end else if ((misal && !eReq) || timeoutNow) begin
            setErr();
        end else begin
            eAlu = cur.aluResult; eIns = cur.ins; eWr = cur.dst;
            eMtr = cur.memtoReg;  eRw = cur.regWrite; eErr = 0;
            eRd  = (eReq && isLoad) ? cur.rdata : 32'h0;
        end
        mReqCycles = eStall ? mReqCycles + 1 : 0;
    endtask

    task automatic edgePhase();
        @(posedge clk);
        #1;
        checkOutput("ALUresultWB", ALUresultWB, eAlu);
        checkOutput("readdataWB", readdataWB, eRd);
        checkOutput("insWB", insWB, eIns);
        checkOutput("writeregWB", 32'(writeregWB), 32'(eWr));
        checkOutput("MemtoRegWB", 32'(MemtoRegWB), 32'(eMtr));
        checkOutput("RegWriteWB", 32'(RegWriteWB), 32'(eRw));
        checkOutput("memerrWB", 32'(memerrWB), 32'(eErr));
    endtask

    task automatic stepCycle();
        combPhase();
        edgePhase();
    endtask

    function automatic stim_t randStim();
        stim_t s;
        int kind;
        kind = $urandom_range(0, 7);
        s = mkStim(kind inside {[2:4], 7}, kind inside {[5:7]}, $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom);
        if ($urandom_range(0, 3) != 0) s.aluResult[1:0] = 2'b00;
        return s;
    endfunction

    initial begin
        vecs[0] = '{mkStim(0,0,32'h100,0,32'hAAAA0001,3,0,1,0,0),             0,0,0, 32'h100, 0,           3, 1, 0};
        vecs[1] = '{mkStim(1,0,32'h10,0,32'hAAAA0002,5,1,1,1,32'hDEADBEEF),     1,0,0, 32'h10, 32'hDEADBEEF, 5, 1, 0};
        vecs[2] = '{mkStim(0,1,32'h24,32'h55,32'hAAAA0003,0,0,0,1,32'h99),     1,1,0, 32'h24, 0,            0, 0, 0};
        vecs[3] = '{mkStim(1,0,32'h13,0,32'hAAAA0004,7,1,1,0,0),               0,0,0, 32'h13, 0,            0, 0, 1};
        vecs[4] = '{mkStim(0,0,32'h200,0,32'hAAAA0005,9,0,1,0,0),              0,0,0, 32'h200, 0,           9, 1, 0};
        vecs[5] = '{mkStim(0,1,32'h22,32'h1,32'hAAAA0006,4,0,1,1,32'h1),       0,0,0, 32'h22, 0,            0, 0, 1};
        vecs[6] = '{mkStim(1,1,32'h30,32'h2,32'hAAAA0007,6,0,1,1,32'h77),      1,1,0, 32'h30, 0,            6, 1, 0};
        vecs[7] = '{mkStim(0,0,32'h300,0,32'hAAAA0008,2,0,0,1,32'hFFFF),       0,0,0, 32'h300, 0,           2, 0, 0};

        // Reset held with an aligned load on the inputs: nothing may leak out.
        applyStimulus(mkStim(1,0,$urandom & ~32'h3,$urandom,$urandom,5'($urandom),1,1,0,$urandom));
        reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) begin
            stepCycle();
            checkOutput("reset_req", 32'(bus.dmem_req), 0);
            checkOutput("reset_RegWriteWB", 32'(RegWriteWB), 0);
        end
        reset = 1'b1;
        applyStimulus(mkStim(0,0,$urandom,$urandom,$urandom,5'($urandom),1,1,0,$urandom));
        stepCycle();
        checkOutput("first_capture_alu", ALUresultWB, cur.aluResult);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].s);
            combPhase();
            checkOutput($sformatf("vec%0d_req", i), 32'(bus.dmem_req), 32'(vecs[i].eReq));
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall_mem), 32'(vecs[i].eStall));
            if (vecs[i].eReq) checkOutput($sformatf("vec%0d_we", i), 32'(bus.dmem_we), 32'(vecs[i].eWe));
            edgePhase();
            checkOutput($sformatf("vec%0d_alu", i), ALUresultWB, vecs[i].eAlu);
            checkOutput($sformatf("vec%0d_rd", i), readdataWB, vecs[i].eRd);
            checkOutput($sformatf("vec%0d_wr", i), 32'(writeregWB), 32'(vecs[i].eWr));
            checkOutput($sformatf("vec%0d_rw", i), 32'(RegWriteWB), 32'(vecs[i].eRw));
            checkOutput($sformatf("vec%0d_err", i), 32'(memerrWB), 32'(vecs[i].eErr));
        end

        // Store completing on the fourth request cycle.
        applyStimulus(mkStim(0,1,32'h20,32'h12345678,32'hBBBB0001,0,0,0,0,0));
        for (int k = 0; k < 3; k++) begin
            combPhase();
            checkOutput("wait3_stall", 32'(stall_mem), 1);
            checkOutput("wait3_we", 32'(bus.dmem_we), 1);
            checkOutput("wait3_addr", bus.dmem_addr, 32'h20);
            edgePhase();
            checkOutput("wait3_bubble_rw", 32'(RegWriteWB), 0);
        end
        cur.ready = 1'b1;
        applyStimulus(cur);
        combPhase();
        checkOutput("wait3_done_stall", 32'(stall_mem), 0);
        edgePhase();
        checkOutput("wait3_done_alu", ALUresultWB, 32'h20);
        checkOutput("wait3_done_err", 32'(memerrWB), 0);

        // Never-ready load times out, then a load whose ready lands on the timeout cycle.
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(mkStim(1,0,32'h40 + 32'(rep*4),0,32'hCCCC0000 + 32'(rep),8,1,1,0,32'hCAFEF00D));
            for (int k = 0; k < TO; k++) begin
                combPhase();
                checkOutput("timeout_stall", 32'(stall_mem), 1);
                edgePhase();
            end
            cur.ready = 1'(rep);
            applyStimulus(cur);
            combPhase();
            checkOutput("timeout_last_stall", 32'(stall_mem), 0);
            checkOutput("timeout_last_req", 32'(bus.dmem_req), 1);
            edgePhase();
            checkOutput("timeout_err", 32'(memerrWB), rep == 0 ? 32'd1 : 32'd0);
            checkOutput("timeout_rw", 32'(RegWriteWB), rep == 0 ? 32'd0 : 32'd1);
            if (rep == 1) checkOutput("timeout_ready_rd", readdataWB, 32'hCAFEF00D);
            applyStimulus(mkStim(0,0,32'h500,0,32'hDDDD0000,1,0,1,0,0));
            stepCycle();
            checkOutput("after_timeout_err", 32'(memerrWB), 0);
        end

        // Reset pulled between edges while the access waits.
        applyStimulus(mkStim(1,0,32'h48,0,32'hEEEE0001,10,1,1,0,0));
        stepCycle();
        stepCycle();
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_req", 32'(bus.dmem_req), 0);
        checkOutput("midreset_stall", 32'(stall_mem), 0);
        checkOutput("midreset_alu", ALUresultWB, 0);
        checkOutput("midreset_rw", 32'(RegWriteWB), 0);
        mReqCycles = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(mkStim(1,0,32'h50,0,32'hEEEE0002,11,1,1,1,32'h0BADF00D));
        stepCycle();
        checkOutput("postreset_rd", readdataWB, 32'h0BADF00D);
        checkOutput("postreset_wr", 32'(writeregWB), 11);

        // Randomized traffic; inputs stay frozen while the stage stalls.
        for (int n = 0; n < 400; n++) begin
            if (eStall) begin
                cur.ready = $urandom_range(0, 3) == 0;
                cur.rdata = $urandom;
                applyStimulus(cur);
            end else begin
                applyStimulus(randStim());
            end
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
